player_move_ctrl: RTL

Sequences one player's grid movement for the Bomberman game. It takes single-cycle direction pulses from the button debouncers, reads the target tile from the shared tile-map RAM through a fixed-latency read port, and commits the move only if the tile is walkable. A cooldown counter then limits the movement rate. Position outputs feed the VGA renderer and the bomb/explosion logic.

---
 rtl/player_move_ctrl_if.sv | 21 ++
 rtl/player_move_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/player_move_ctrl_if.sv
// Tile-map read port shared between the movement controller and the map RAM.
interface player_move_ctrl_if;
  logic       map_rd_en;
  logic [3:0] map_rd_x;
  logic [3:0] map_rd_y;
  logic [1:0] map_rd_data;

  modport master (
    output map_rd_en,
    output map_rd_x,
    output map_rd_y,
    input  map_rd_data
  );

  modport slave (
    input  map_rd_en,
    input  map_rd_x,
    input  map_rd_y,
    output map_rd_data
  );
endinterface

// File: rtl/player_move_ctrl.sv
// Grid movement sequencer for one player: picks a direction, checks the
// target tile through a one-cycle-latency map read, commits walkable moves
// and then enforces a cooldown before the next move is accepted.
module player_move_ctrl #(
  parameter int unsigned GRID_W   = 15,
  parameter int unsigned GRID_H   = 13,
  parameter int unsigned COOLDOWN = 10_000_000,
  parameter int unsigned START_X  = 1,
  parameter int unsigned START_Y  = 1
) (
  input  logic                      sys_clk,
  input  logic                      Reset,
  input  logic                      enable,
  input  logic                      btn_u,
  input  logic                      btn_d,
  input  logic                      btn_l,
  input  logic                      btn_r,
  player_move_ctrl_if.master        map,
  output logic [3:0]                pos_x,
  output logic [3:0]                pos_y,
  output logic                      moved,
  output logic                      blocked,
  output logic                      busy
);

  localparam int unsigned    CW       = $clog2(COOLDOWN + 1);
  localparam logic [CW-1:0]  CNT_LOAD = CW'(COOLDOWN - 1);
  localparam logic [3:0]     X_MAX    = 4'(GRID_W - 1);
  localparam logic [3:0]     Y_MAX    = 4'(GRID_H - 1);
  localparam logic [3:0]     X_RST    = 4'(START_X);
  localparam logic [3:0]     Y_RST    = 4'(START_Y);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, COOL} state_t;

  state_t        state, state_n;
  logic [3:0]    tgt_x, tgt_y, tgt_x_n, tgt_y_n;
  logic [3:0]    pos_x_n, pos_y_n;
  logic [3:0]    tx, ty;
  logic          oob;
  logic [CW-1:0] cnt, cnt_n;
  logic          moved_n, blocked_n;

  // State register.
  always_ff @(posedge sys_clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state and next-output logic; direction priority U > D > L > R.
  always_comb begin
    state_n   = state;
    tgt_x_n   = tgt_x;
    tgt_y_n   = tgt_y;
    pos_x_n   = pos_x;
    pos_y_n   = pos_y;
    cnt_n     = cnt;
    moved_n   = 1'b0;
    blocked_n = 1'b0;
    oob       = 1'b0;
    tx        = pos_x;
    ty        = pos_y;
    unique case (state)
      IDLE: begin
        if (enable && (btn_u || btn_d || btn_l || btn_r)) begin
          if (btn_u) begin
            oob = (pos_y == '0);
            ty  = pos_y - 4'd1;
          end else if (btn_d) begin
            oob = (pos_y == Y_MAX);
            ty  = pos_y + 4'd1;
          end else if (btn_l) begin
            oob = (pos_x == '0);
            tx  = pos_x - 4'd1;
          end else begin
            oob = (pos_x == X_MAX);
            tx  = pos_x + 4'd1;
          end
          if (oob) begin
            blocked_n = 1'b1;
          end else begin
            tgt_x_n = tx;
            tgt_y_n = ty;
            state_n = REQ;
          end
        end
      end
      REQ: state_n = WAIT;
      WAIT: begin
        if (map.map_rd_data == 2'b00) begin
          pos_x_n = tgt_x;
          pos_y_n = tgt_y;
          moved_n = 1'b1;
          cnt_n   = CNT_LOAD;
          state_n = COOL;
        end else begin
          blocked_n = 1'b1;
          state_n   = IDLE;
        end
      end
      COOL: begin
        if (cnt == '0) state_n = IDLE;
        else           cnt_n   = cnt - 1'b1;
      end
    endcase
  end

  // Registered datapath and outputs, derived from the next state so every
  // output changes on the same edge as the state it belongs to.
  always_ff @(posedge sys_clk or posedge Reset) begin
    if (Reset) begin
      tgt_x         <= '0;
      tgt_y         <= '0;
      pos_x         <= X_RST;
      pos_y         <= Y_RST;
      cnt           <= '0;
      moved         <= 1'b0;
      blocked       <= 1'b0;
      busy          <= 1'b0;
      map.map_rd_en <= 1'b0;
      map.map_rd_x  <= '0;
      map.map_rd_y  <= '0;
    end else begin
      tgt_x         <= tgt_x_n;
      tgt_y         <= tgt_y_n;
      pos_x         <= pos_x_n;
      pos_y         <= pos_y_n;
      cnt           <= cnt_n;
      moved         <= moved_n;
      blocked       <= blocked_n;
      busy          <= (state_n != IDLE);
      map.map_rd_en <= (state_n == REQ);
      if (state_n == REQ) begin
        map.map_rd_x <= tgt_x_n;
        map.map_rd_y <= tgt_y_n;
      end
    end
  end

endmodule
